// File: rtl/pec_ctrl.sv
// PE-cluster controller: sequences weight capture, activation hand-off, MAC start/finish
// and partial-sum SRAM read/write addressing for one PE in a chain.
module pec_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int CHANNEL_DEPTH = 32,
   parameter int KERNEL        = 3,
   parameter int PSUM_DEPTH    = 16,
   localparam int NUM_MAC      = KERNEL * KERNEL,
   localparam int AW           = $clog2(PSUM_DEPTH),
   localparam int KW           = $clog2(KERNEL) + 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [KW-1:0]                       CfgKerRow,
   input  logic                                CfgFrtBlk,
   input  logic                                CfgLstPec,
   input  logic                                DISWEIPEC_RdyWei,
   output logic                                PECDISWEI_GetWei,
   input  logic                                LSTPEC_RdyAct,
   output logic                                LSTPEC_GetAct,
   input  logic                                LSTPEC_FrtActRow,
   input  logic                                LSTPEC_LstActRow,
   input  logic                                LSTPEC_LstActBlk,
   input  logic [CHANNEL_DEPTH-1:0]            PEBPEC_FlgAct,
   input  logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] PEBPEC_Act,
   output logic                                NXTPEC_RdyAct,
   input  logic                                NXTPEC_GetAct,
   output logic                                NXTPEC_FrtActRow,
   output logic                                NXTPEC_LstActRow,
   output logic                                NXTPEC_LstActBlk,
   output logic [CHANNEL_DEPTH-1:0]            PECMAC_FlgAct,
   output logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] PECMAC_Act,
   output logic                                PECMAC_Sta,
   output logic [NUM_MAC-1:0]                  PECMAC_En,
   input  logic [NUM_MAC-1:0]                  MACPEC_Fnh,
   output logic                                PECCNV_PlsAcc,
   output logic                                PECCNV_FnhRow,
   output logic                                PECCNV_ZeroPsum,
   output logic                                PECRAM_EnRd,
   output logic [AW-1:0]                       PECRAM_AddrRd,
   output logic                                PECRAM_EnWr,
   output logic [AW-1:0]                       PECRAM_AddrWr
);

   typedef enum logic [2:0] {IDLE, CFGWEI, CFGACT, COMP, WAITGET} stateType;

   stateType                        state;
   logic                            cfgFrtBlk;
   logic                            cfgLstPec;
   logic [NUM_MAC-1:0]              macEn;
   logic [DATA_WIDTH*CHANNEL_DEPTH-1:0] actReg;
   logic [CHANNEL_DEPTH-1:0]        flgReg;
   logic                            frtRow;
   logic                            lstRow;
   logic                            lstBlk;
   logic                            sta;
   logic                            plsAcc;
   logic                            fnhRow;
   logic                            enRd;
   logic                            enWr;
   logic [AW-1:0]                   addrRd;
   logic [AW-1:0]                   addrWr;
   logic                            nxtRdy;
   logic                            allFnh;

   // Rows beyond the active kernel height are masked off; zero selects the full kernel.
   function automatic logic [NUM_MAC-1:0] rowMask(input logic [KW-1:0] rows);
      logic [NUM_MAC-1:0] m;
      int n;
      n = (rows == '0) ? KERNEL : int'(rows);
      m = '0;
      for (int r = 0; r < KERNEL; r++)
         for (int c = 0; c < KERNEL; c++)
            if (r < n) m[r*KERNEL+c] = 1'b1;
      return m;
   endfunction

   function automatic logic [AW-1:0] nextAddr(input logic [AW-1:0] a);
      return (a == AW'(PSUM_DEPTH-1)) ? '0 : a + 1'b1;
   endfunction

   // Handshake acknowledges answer in the same cycle the request is seen.
   assign allFnh           = &(MACPEC_Fnh | ~macEn);
   assign PECDISWEI_GetWei = (state == CFGWEI) && DISWEIPEC_RdyWei;
   assign LSTPEC_GetAct    = (state == CFGACT) && LSTPEC_RdyAct;

   // Single sequencing block: state, latched config, held activation, pulses and addresses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cfgFrtBlk <= 1'b0;
         cfgLstPec <= 1'b0;
         macEn     <= '0;
         actReg    <= '0;
         flgReg    <= '0;
         frtRow    <= 1'b0;
         lstRow    <= 1'b0;
         lstBlk    <= 1'b0;
         sta       <= 1'b0;
         plsAcc    <= 1'b0;
         fnhRow    <= 1'b0;
         enRd      <= 1'b0;
         enWr      <= 1'b0;
         addrRd    <= '0;
         addrWr    <= '0;
         nxtRdy    <= 1'b0;
      end else begin
         sta    <= 1'b0;
         plsAcc <= 1'b0;
         fnhRow <= 1'b0;
         enRd   <= 1'b0;
         enWr   <= 1'b0;

         // End of a channel block rewinds both psum pointers, overriding any increment.
         if (plsAcc && lstBlk) begin
            addrRd <= '0;
            addrWr <= '0;
         end else begin
            if (enRd) addrRd <= nextAddr(addrRd);
            if (enWr) addrWr <= nextAddr(addrWr);
         end

         case (state)
            IDLE: state <= CFGWEI;
            CFGWEI: begin
               if (DISWEIPEC_RdyWei) begin
                  cfgFrtBlk <= CfgFrtBlk;
                  cfgLstPec <= CfgLstPec;
                  macEn     <= rowMask(CfgKerRow);
                  state     <= CFGACT;
               end
            end
            CFGACT: begin
               if (LSTPEC_RdyAct) begin
                  actReg <= PEBPEC_Act;
                  flgReg <= PEBPEC_FlgAct;
                  frtRow <= LSTPEC_FrtActRow;
                  lstRow <= LSTPEC_LstActRow;
                  lstBlk <= LSTPEC_LstActBlk;
                  sta    <= 1'b1;
                  enRd   <= LSTPEC_FrtActRow && !cfgFrtBlk;
                  state  <= COMP;
               end
            end
            COMP: begin
               if (!sta && allFnh) begin
                  plsAcc <= 1'b1;
                  fnhRow <= lstRow;
                  enWr   <= lstRow;
                  nxtRdy <= 1'b1;
                  state  <= WAITGET;
               end
            end
            WAITGET: begin
               if (NXTPEC_GetAct || cfgLstPec) begin
                  nxtRdy <= 1'b0;
                  state  <= lstBlk ? IDLE : CFGACT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign NXTPEC_RdyAct    = nxtRdy;
   assign NXTPEC_FrtActRow = frtRow;
   assign NXTPEC_LstActRow = lstRow;
   assign NXTPEC_LstActBlk = lstBlk;
   assign PECMAC_FlgAct    = flgReg;
   assign PECMAC_Act       = actReg;
   assign PECMAC_Sta       = sta;
   assign PECMAC_En        = macEn;
   assign PECCNV_PlsAcc    = plsAcc;
   assign PECCNV_FnhRow    = fnhRow;
   assign PECCNV_ZeroPsum  = cfgFrtBlk;
   assign PECRAM_EnRd      = enRd;
   assign PECRAM_AddrRd    = addrRd;
   assign PECRAM_EnWr      = enWr;
   assign PECRAM_AddrWr    = addrWr;

endmodule

// File: tb/tb_pec_ctrl.sv
// Self-checking bench for pec_ctrl: vector table of single-row blocks plus hand sequences,
// with SRAM accesses and accumulate pulses scored against queued expectations.
module tb_pec_ctrl;

   localparam int DW = 8;
   localparam int CD = 32;
   localparam int K  = 3;
   localparam int PD = 16;
   localparam int NM = K * K;
   localparam int AW = $clog2(PD);
   localparam int KW = $clog2(K) + 1;

   logic              clk;
   logic              rst_n;
   logic [KW-1:0]     CfgKerRow;
   logic              CfgFrtBlk;
   logic              CfgLstPec;
   logic              DISWEIPEC_RdyWei;
   logic              PECDISWEI_GetWei;
   logic              LSTPEC_RdyAct;
   logic              LSTPEC_GetAct;
   logic              LSTPEC_FrtActRow;
   logic              LSTPEC_LstActRow;
   logic              LSTPEC_LstActBlk;
   logic [CD-1:0]     PEBPEC_FlgAct;
   logic [DW*CD-1:0]  PEBPEC_Act;
   logic              NXTPEC_RdyAct;
   logic              NXTPEC_GetAct;
   logic              NXTPEC_FrtActRow;
   logic              NXTPEC_LstActRow;
   logic              NXTPEC_LstActBlk;
   logic [CD-1:0]     PECMAC_FlgAct;
   logic [DW*CD-1:0]  PECMAC_Act;
   logic              PECMAC_Sta;
   logic [NM-1:0]     PECMAC_En;
   logic [NM-1:0]     MACPEC_Fnh;
   logic              PECCNV_PlsAcc;
   logic              PECCNV_FnhRow;
   logic              PECCNV_ZeroPsum;
   logic              PECRAM_EnRd;
   logic [AW-1:0]     PECRAM_AddrRd;
   logic              PECRAM_EnWr;
   logic [AW-1:0]     PECRAM_AddrWr;

   pec_ctrl #(.DATA_WIDTH(DW), .CHANNEL_DEPTH(CD), .KERNEL(K), .PSUM_DEPTH(PD)) dut (
      .clk(clk), .rst_n(rst_n),
      .CfgKerRow(CfgKerRow), .CfgFrtBlk(CfgFrtBlk), .CfgLstPec(CfgLstPec),
      .DISWEIPEC_RdyWei(DISWEIPEC_RdyWei), .PECDISWEI_GetWei(PECDISWEI_GetWei),
      .LSTPEC_RdyAct(LSTPEC_RdyAct), .LSTPEC_GetAct(LSTPEC_GetAct),
      .LSTPEC_FrtActRow(LSTPEC_FrtActRow), .LSTPEC_LstActRow(LSTPEC_LstActRow),
      .LSTPEC_LstActBlk(LSTPEC_LstActBlk),
      .PEBPEC_FlgAct(PEBPEC_FlgAct), .PEBPEC_Act(PEBPEC_Act),
      .NXTPEC_RdyAct(NXTPEC_RdyAct), .NXTPEC_GetAct(NXTPEC_GetAct),
      .NXTPEC_FrtActRow(NXTPEC_FrtActRow), .NXTPEC_LstActRow(NXTPEC_LstActRow),
      .NXTPEC_LstActBlk(NXTPEC_LstActBlk),
      .PECMAC_FlgAct(PECMAC_FlgAct), .PECMAC_Act(PECMAC_Act),
      .PECMAC_Sta(PECMAC_Sta), .PECMAC_En(PECMAC_En), .MACPEC_Fnh(MACPEC_Fnh),
      .PECCNV_PlsAcc(PECCNV_PlsAcc), .PECCNV_FnhRow(PECCNV_FnhRow),
      .PECCNV_ZeroPsum(PECCNV_ZeroPsum),
      .PECRAM_EnRd(PECRAM_EnRd), .PECRAM_AddrRd(PECRAM_AddrRd),
      .PECRAM_EnWr(PECRAM_EnWr), .PECRAM_AddrWr(PECRAM_AddrWr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [KW-1:0] kerRow;
      logic          frtBlk;
      logic          lstPec;
      logic [7:0]    act;
      logic [CD-1:0] flg;
      logic          frtRow;
      logic          lstRow;
      logic [NM-1:0] fnh;
      logic [NM-1:0] expMask;
      bit            expPls;
      int            hold;
   } vecT;

   vecT  vecs[6];
   int   assertCount = 0;
   int   failCount   = 0;
   int   rdQ[$];
   int   wrQ[$];
   bit   plsQ[$];
   int   rdModel = 0;
   int   wrModel = 0;
   bit   modelFrtBlk = 0;
   logic [NM-1:0] curMask = '0;
   bit   inCfgAct = 0;
   bit   prevSta = 0, prevPls = 0, prevRd = 0, prevWr = 0;

   // Global guard so a wedged DUT can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkAct(input string name, input logic [7:0] act, input logic [CD-1:0] flg);
      assertCount++;
      if (PECMAC_Act !== {CD{act}} || PECMAC_FlgAct !== flg) begin
         failCount++;
         $display("[TB] FAIL %s: got act 0x%0h flg 0x%0h, expected act byte 0x%0h flg 0x%0h",
                  name, PECMAC_Act[31:0], PECMAC_FlgAct, act, flg);
      end
   endtask

   // Per-cycle scoreboard: pops expected SRAM addresses / row-done flags as pulses appear.
   task automatic monitor;
      if (PECMAC_Sta)    checkOutput("staWidth", prevSta, 0);
      if (PECCNV_PlsAcc) checkOutput("plsAccWidth", prevPls, 0);
      if (PECRAM_EnRd)   checkOutput("enRdWidth", prevRd, 0);
      if (PECRAM_EnWr)   checkOutput("enWrWidth", prevWr, 0);
      prevSta = PECMAC_Sta; prevPls = PECCNV_PlsAcc; prevRd = PECRAM_EnRd; prevWr = PECRAM_EnWr;
      if (PECRAM_EnRd) begin
         if (rdQ.size() == 0) checkOutput("unexpectedRead", 1, 0);
         else checkOutput("rdAddr", PECRAM_AddrRd, rdQ.pop_front());
      end
      if (PECRAM_EnWr) begin
         checkOutput("wrWithFnhRow", PECCNV_FnhRow, 1);
         if (wrQ.size() == 0) checkOutput("unexpectedWrite", 1, 0);
         else checkOutput("wrAddr", PECRAM_AddrWr, wrQ.pop_front());
      end
      if (PECCNV_PlsAcc) begin
         if (plsQ.size() == 0) checkOutput("unexpectedPlsAcc", 1, 0);
         else checkOutput("fnhRow", PECCNV_FnhRow, plsQ.pop_front());
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      monitor();
   endtask

   task automatic loadWeights(input logic [KW-1:0] kerRow, input logic frtBlk, input logic lstPec,
                              input logic [NM-1:0] expMask);
      bit got;
      got = 0;
      CfgKerRow = kerRow; CfgFrtBlk = frtBlk; CfgLstPec = lstPec; DISWEIPEC_RdyWei = 1'b1;
      for (int n = 0; n < 8; n++) begin
         #1;
         if (PECDISWEI_GetWei) begin got = 1; break; end
         tick();
      end
      checkOutput("getWeiSeen", got, 1);
      tick();
      #1;
      checkOutput("getWeiPulse", PECDISWEI_GetWei, 0);
      DISWEIPEC_RdyWei = 1'b0;
      CfgFrtBlk = ~frtBlk; CfgLstPec = ~lstPec; CfgKerRow = kerRow + 1'b1;
      checkOutput("macEnMask", PECMAC_En, expMask);
      checkOutput("zeroPsum", PECCNV_ZeroPsum, frtBlk);
      modelFrtBlk = frtBlk;
      curMask = expMask;
      inCfgAct = 1;
   endtask

   task automatic sendRow(input logic [7:0] act, input logic [CD-1:0] flg, input logic frt,
                          input logic lst, input logic blk, input logic [NM-1:0] fnh,
                          input bit expPls, input int hold, input bit lstPec);
      bit got;
      int n;
      LSTPEC_RdyAct = 1'b1; PEBPEC_Act = {CD{act}}; PEBPEC_FlgAct = flg;
      LSTPEC_FrtActRow = frt; LSTPEC_LstActRow = lst; LSTPEC_LstActBlk = blk;
      if (inCfgAct) begin
         #1;
         checkOutput("getActImmediate", LSTPEC_GetAct, 1);
      end
      got = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (LSTPEC_GetAct) begin got = 1; break; end
         tick();
      end
      checkOutput("getActSeen", got, 1);
      if (frt && !modelFrtBlk) begin rdQ.push_back(rdModel); rdModel = (rdModel + 1) % PD; end
      plsQ.push_back(lst);
      if (lst) begin wrQ.push_back(wrModel); wrModel = (wrModel + 1) % PD; end
      if (blk) begin rdModel = 0; wrModel = 0; end
      tick();
      #1;
      checkOutput("getActPulse", LSTPEC_GetAct, 0);
      LSTPEC_RdyAct = 1'b0;
      PEBPEC_Act = ~PEBPEC_Act; PEBPEC_FlgAct = ~flg;
      LSTPEC_FrtActRow = ~frt; LSTPEC_LstActRow = ~lst; LSTPEC_LstActBlk = ~blk;
      checkOutput("staPulse", PECMAC_Sta, 1);
      checkAct("actCaptured", act, flg);
      MACPEC_Fnh = fnh;
      if (!expPls) begin
         got = 0;
         for (int i = 0; i < 6; i++) begin
            tick();
            if (PECCNV_PlsAcc) got = 1;
         end
         checkOutput("noPlsAccPartialFnh", got, 0);
         MACPEC_Fnh = '1;
      end
      got = 0;
      for (n = 0; n < 10; n++) begin
         tick();
         if (PECCNV_PlsAcc) begin got = 1; break; end
      end
      checkOutput("plsAccSeen", got, 1);
      checkOutput("plsAccLatency", n, expPls ? 1 : 0);
      checkAct("actHeld", act, flg);
      checkOutput("nxtRdySet", NXTPEC_RdyAct, 1);
      checkOutput("nxtTags", {NXTPEC_FrtActRow, NXTPEC_LstActRow, NXTPEC_LstActBlk}, {frt, lst, blk});
      MACPEC_Fnh = '0;
      if (!lstPec) begin
         for (int i = 0; i < hold; i++) begin
            LSTPEC_RdyAct = 1'b1; DISWEIPEC_RdyWei = 1'b1;
            #1;
            checkOutput("holdNoGet", {LSTPEC_GetAct, PECDISWEI_GetWei, NXTPEC_RdyAct}, 3'b001);
            tick();
         end
         LSTPEC_RdyAct = 1'b0; DISWEIPEC_RdyWei = 1'b0;
         checkOutput("macEnStable", PECMAC_En, curMask);
         NXTPEC_GetAct = 1'b1;
         tick();
         NXTPEC_GetAct = 1'b0;
      end else begin
         tick();
      end
      checkOutput("nxtRdyClr", NXTPEC_RdyAct, 0);
      inCfgAct = !blk;
   endtask

   task automatic applyStimulus(input vecT v);
      loadWeights(v.kerRow, v.frtBlk, v.lstPec, v.expMask);
      sendRow(v.act, v.flg, v.frtRow, v.lstRow, 1'b1, v.fnh, v.expPls, v.hold, v.lstPec);
   endtask

   initial begin
      bit sawSta, sawGet;
      vecs[0] = '{kerRow:3'd0, frtBlk:1'b0, lstPec:1'b1, act:8'hA5, flg:32'hFFFF_FFFF, frtRow:1'b1,
                  lstRow:1'b1, fnh:9'h1FF, expMask:9'h1FF, expPls:1'b1, hold:0};
      vecs[1] = '{kerRow:3'd2, frtBlk:1'b0, lstPec:1'b1, act:8'h3C, flg:32'h0F0F_0F0F, frtRow:1'b1,
                  lstRow:1'b0, fnh:9'h03F, expMask:9'h03F, expPls:1'b1, hold:0};
      vecs[2] = '{kerRow:3'd2, frtBlk:1'b0, lstPec:1'b1, act:8'h81, flg:32'h1234_5678, frtRow:1'b0,
                  lstRow:1'b1, fnh:9'h01F, expMask:9'h03F, expPls:1'b0, hold:0};
      vecs[3] = '{kerRow:3'd1, frtBlk:1'b1, lstPec:1'b1, act:8'h77, flg:32'hAAAA_5555, frtRow:1'b1,
                  lstRow:1'b1, fnh:9'h007, expMask:9'h007, expPls:1'b1, hold:0};
      vecs[4] = '{kerRow:3'd3, frtBlk:1'b0, lstPec:1'b0, act:8'h5A, flg:32'h0000_FFFF, frtRow:1'b0,
                  lstRow:1'b1, fnh:9'h1FF, expMask:9'h1FF, expPls:1'b1, hold:10};
      vecs[5] = '{kerRow:3'd1, frtBlk:1'b0, lstPec:1'b0, act:8'hC3, flg:32'hDEAD_BEEF, frtRow:1'b1,
                  lstRow:1'b1, fnh:9'h0C7, expMask:9'h007, expPls:1'b1, hold:2};

      rst_n = 1'b0; CfgKerRow = '0; CfgFrtBlk = 1'b0; CfgLstPec = 1'b0; DISWEIPEC_RdyWei = 1'b1;
      LSTPEC_RdyAct = 1'b0; LSTPEC_FrtActRow = 1'b0; LSTPEC_LstActRow = 1'b0; LSTPEC_LstActBlk = 1'b0;
      PEBPEC_FlgAct = '0; PEBPEC_Act = '0; NXTPEC_GetAct = 1'b0; MACPEC_Fnh = '0;
      tick();
      tick();
      checkOutput("resetOutputs", {PECDISWEI_GetWei, PECMAC_Sta, PECMAC_En, NXTPEC_RdyAct,
                  PECCNV_ZeroPsum, PECRAM_AddrRd, PECRAM_AddrWr}, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("idleNoGetWei", PECDISWEI_GetWei, 0);
      tick();
      #1;
      checkOutput("cfgWeiCycle2", PECDISWEI_GetWei, 1);

      $display("[TB] vector table");
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      $display("[TB] psum address wrap over 18 rows");
      loadWeights(3'd0, 1'b0, 1'b1, 9'h1FF);
      for (int r = 0; r < 18; r++) begin
         if (r == 17) checkOutput("addrBeforeLast", {PECRAM_AddrRd, PECRAM_AddrWr}, {4'd1, 4'd1});
         sendRow(8'(r), 32'(r), 1'b1, 1'b1, r == 17, 9'h1FF, 1'b1, 0, 1'b1);
      end
      checkOutput("addrClearedOnBlk", {PECRAM_AddrRd, PECRAM_AddrWr}, 0);

      $display("[TB] reset during compute");
      loadWeights(3'd2, 1'b0, 1'b1, 9'h03F);
      sendRow(8'h11, 32'h1, 1'b1, 1'b1, 1'b0, 9'h03F, 1'b1, 0, 1'b1);
      LSTPEC_RdyAct = 1'b1; PEBPEC_Act = {CD{8'h99}}; PEBPEC_FlgAct = '1;
      LSTPEC_FrtActRow = 1'b0; LSTPEC_LstActRow = 1'b1; LSTPEC_LstActBlk = 1'b1; MACPEC_Fnh = '0;
      tick();
      tick();
      checkOutput("addrBeforeReset", {PECRAM_AddrRd, PECRAM_AddrWr}, {4'd1, 4'd1});
      rst_n = 1'b0;
      #1;
      checkOutput("asyncResetCtl", {PECMAC_Sta, PECMAC_En, NXTPEC_RdyAct, NXTPEC_FrtActRow,
                  NXTPEC_LstActRow, NXTPEC_LstActBlk, PECCNV_PlsAcc, PECCNV_ZeroPsum,
                  PECRAM_AddrRd, PECRAM_AddrWr, LSTPEC_GetAct, PECDISWEI_GetWei}, 0);
      checkAct("asyncResetAct", 8'h00, '0);
      rdModel = 0; wrModel = 0; inCfgAct = 0;
      tick();
      rst_n = 1'b1;
      sawSta = 0; sawGet = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (LSTPEC_GetAct) sawGet = 1;
         tick();
         if (PECMAC_Sta) sawSta = 1;
      end
      checkOutput("noGetActBeforeWei", sawGet, 0);
      checkOutput("noStaBeforeWei", sawSta, 0);
      loadWeights(3'd0, 1'b0, 1'b1, 9'h1FF);
      sendRow(8'h22, 32'h2, 1'b1, 1'b1, 1'b1, 9'h1FF, 1'b1, 0, 1'b1);

      checkOutput("rdQEmpty", rdQ.size(), 0);
      checkOutput("wrQEmpty", wrQ.size(), 0);
      checkOutput("plsQEmpty", plsQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/pec_ctrl.md
PEC_CTRL -- requirements
Module: pec_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, activation bit width.
REQ-002 SHALL have parameter CHANNEL_DEPTH, default 32, channels per activation word.
REQ-003 SHALL have parameter KERNEL, default 3, kernel side; NUM_MAC = KERNEL*KERNEL.
REQ-004 SHALL have parameter PSUM_DEPTH, default 16, psum SRAM rows; AW = clog2(PSUM_DEPTH).
REQ-005 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- CfgKerRow  in  clog2(KERNEL)+1  active kernel rows; 0 means KERNEL.
- CfgFrtBlk  in  1  first channel block; psum starts from zero.
- CfgLstPec  in  1  last PE in chain; no downstream handshake.
- DISWEIPEC_RdyWei  in  1  weights valid (level).
- PECDISWEI_GetWei  out  1  weights consumed (pulse).
- LSTPEC_RdyAct  in  1  upstream activation valid (level).
- LSTPEC_GetAct  out  1  upstream activation taken (pulse).
- LSTPEC_FrtActRow / LSTPEC_LstActRow / LSTPEC_LstActBlk  in  1 each  tags of upstream activation.
- PEBPEC_FlgAct  in  CHANNEL_DEPTH  sparsity flags; PEBPEC_Act  in  DATA_WIDTH*CHANNEL_DEPTH  activations.
- NXTPEC_RdyAct  out  1  held activation available downstream.
- NXTPEC_GetAct  in  1  downstream took activation (pulse).
- NXTPEC_FrtActRow / NXTPEC_LstActRow / NXTPEC_LstActBlk  out  1 each  registered tags.
- PECMAC_FlgAct  out  CHANNEL_DEPTH; PECMAC_Act  out  DATA_WIDTH*CHANNEL_DEPTH  registered activation.
- PECMAC_Sta  out  1  MAC start pulse; PECMAC_En  out  NUM_MAC  MAC enable mask.
- MACPEC_Fnh  in  NUM_MAC  per-MAC finish (level).
- PECCNV_PlsAcc  out  1  accumulate pulse; PECCNV_FnhRow  out  1  row-done pulse; PECCNV_ZeroPsum  out  1  use zero instead of SRAM psum.
- PECRAM_EnRd  out  1; PECRAM_AddrRd  out  AW; PECRAM_EnWr  out  1; PECRAM_AddrWr  out  AW.

Function
REQ-006 FSM states IDLE, CFGWEI, CFGACT, COMP, WAITGET; IDLE -> CFGWEI unconditionally next cycle.
REQ-007 CFGWEI: when DISWEIPEC_RdyWei=1, PECDISWEI_GetWei pulses 1 cycle, CfgKerRow/CfgFrtBlk/CfgLstPec latched, -> CFGACT; config ignored in all other states.
REQ-008 PECMAC_En bit r*KERNEL+c = 1 iff r < latched CfgKerRow (0 -> all ones); held until next CFGWEI capture.
REQ-009 CFGACT: when LSTPEC_RdyAct=1, LSTPEC_GetAct pulses same cycle, Act/FlgAct/tags registered at that edge, -> COMP; PECMAC_Sta pulses the following cycle.
REQ-010 COMP: AllFnh = AND over (MACPEC_Fnh | ~PECMAC_En), ignored in Sta cycle; first cycle AllFnh=1 after Sta: PECCNV_PlsAcc pulses 1 cycle, -> WAITGET.
REQ-011 WAITGET: NXTPEC_RdyAct=1 (registered, state-decoded); exit on NXTPEC_GetAct=1 or latched CfgLstPec=1 (next cycle); exit -> IDLE if held LstActBlk=1 else CFGACT.
REQ-012 NXTPEC_GetAct outside WAITGET SHALL be ignored; LSTPEC_RdyAct outside CFGACT SHALL be ignored.
REQ-013 PECCNV_FnhRow = PECCNV_PlsAcc AND held LstActRow.
REQ-014 Read: EnRd pulses in Sta cycle when held FrtActRow=1 and latched CfgFrtBlk=0, at AddrRd; AddrRd increments after each read.
REQ-015 PECCNV_ZeroPsum = latched CfgFrtBlk; no SRAM reads while 1.
REQ-016 Write: EnWr pulses with PECCNV_FnhRow at AddrWr; AddrWr increments after each write.
REQ-017 Addresses wrap PSUM_DEPTH-1 -> 0; both clear to 0 on PlsAcc with held LstActBlk=1, clear taking priority over increment.
REQ-018 Sta, PlsAcc, FnhRow, EnRd, EnWr, GetAct, GetWei SHALL never exceed 1 cycle per event.

Reset
REQ-019 rst_n=0 asynchronously: state IDLE, all outputs 0 (including PECMAC_En, addresses, registered Act/Flg/tags, latched config), regardless of state mid-operation.
REQ-020 After rst_n release, first activity is CFGWEI in cycle 2; no MAC start before a weight capture.

Verification
REQ-021 RdyWei=1, CfgKerRow=0, RdyAct=1, Act=0xA5 per channel -> GetWei then GetAct pulse, Sta one cycle later, PECMAC_En=0x1FF, PECMAC_Act=0xA5.. held.
REQ-022 CfgKerRow=2, MACPEC_Fnh=0x03F -> PlsAcc pulses once, Fnh[8:6] ignored; Fnh=0x01F -> no PlsAcc.
REQ-023 CfgLstPec=0, GetAct withheld 10 cycles -> NXTPEC_RdyAct=1 all 10, no new LSTPEC_GetAct; GetAct pulse -> CFGACT next cycle.
REQ-024 PSUM_DEPTH=16, 18 rows FrtActRow/LstActRow=1, CfgFrtBlk=0 -> EnRd/EnWr addresses 0..15,0,1; LstActBlk on last -> both addresses 0.
REQ-025 CfgFrtBlk=1 -> ZeroPsum=1, EnRd never asserted, EnWr still pulses per row.
REQ-026 rst_n low during COMP -> all outputs 0 immediately; after release, GetWei required before next Sta.
